// File: rtl/audplay_pkg.sv
// audplay_pkg: bus widths, register map, status bits and link states for the audio playback block
package audplay_pkg;

    localparam int ADP_VA_WIDTH  = 3;
    localparam int BUS_WIDTH     = 32;
    localparam int BUS_ACC_WIDTH = 2;

    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

    localparam logic [ADP_VA_WIDTH-1:0] REG_SDR = 3'd0;
    localparam logic [ADP_VA_WIDTH-1:0] REG_SR  = 3'd4;

    localparam int SR_EMPTY     = 0;
    localparam int SR_FULL      = 1;
    localparam int SR_UNDERRUN  = 2;
    localparam int SR_LEVEL_LSB = 4;

    localparam int FRAME_HALF  = 64;
    localparam int SAMPLE_BITS = 24;

    typedef enum logic [1:0] {
        LINK_IDLE = 2'd0,
        LINK_LOW  = 2'd1,
        LINK_HIGH = 2'd2
    } link_state_e;

    // Status word as software sees it; unused bits read as zero.
    function automatic logic [BUS_WIDTH-1:0] sr_pack(input logic empty, input logic full,
                                                     input logic underrun, input logic [3:0] level);
        logic [BUS_WIDTH-1:0] sr;
        sr = '0;
        sr[SR_EMPTY] = empty;
        sr[SR_FULL] = full;
        sr[SR_UNDERRUN] = underrun;
        sr[SR_LEVEL_LSB +: 4] = level;
        return sr;
    endfunction

endpackage

// File: rtl/audplay_fifo.sv
// audplay_fifo: FIFO_DEPTH x 24-bit sample FIFO with the head visible combinationally
module audplay_fifo
    import audplay_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push,
    input  logic                          pop,
    input  logic [SAMPLE_BITS-1:0]        din,
    output logic [SAMPLE_BITS-1:0]        dout,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          empty,
    output logic                          full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [SAMPLE_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_q;
    logic [AW-1:0]          rd_q;
    logic [LW-1:0]          level_q;

    // Storage is not reset: clearing the pointers is enough to discard contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    assign dout  = mem_q[rd_q];
    assign level = level_q;
    assign empty = level_q == '0;
    assign full  = level_q == LW'(FIFO_DEPTH);

endmodule

// File: rtl/audplay_controller.sv
// audplay_controller: bus-fed sample FIFO driving a clock-master three-wire serial audio link
module audplay_controller
    import audplay_pkg::*;
#(
    parameter int PRIMARY_DIV = 26,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [ADP_VA_WIDTH-1:0]  addr,
    input  logic                     w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] acc,
    output logic [BUS_WIDTH-1:0]     rdata,
    input  logic [BUS_WIDTH-1:0]     wdata,
    input  logic                     req,
    output logic                     resp,
    output logic                     fault,
    output logic                     sck,
    output logic                     ws,
    output logic                     sd
);

    localparam int DW = $clog2(PRIMARY_DIV);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [DW-1:0]          div_q, div_d;
    link_state_e            state_q, state_d;
    logic [5:0]             count_q, count_d;
    logic [SAMPLE_BITS-1:0] hold_q, hold_d;
    logic                   underrun_q, underrun_d;
    logic                   resp_q;
    logic [BUS_WIDTH-1:0]   rdata_q, rdata_d;

    logic                   tick;
    logic                   load;
    logic                   wr_ok;
    logic                   rd_ok;
    logic                   pop;
    logic [SAMPLE_BITS-1:0] fifo_dout;
    logic [LW-1:0]          fifo_level;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [4:0]             bit_idx;
    logic                   unused_wdata;

    assign unused_wdata = ^wdata[BUS_WIDTH-1:SAMPLE_BITS];

    // Only 4-byte SDR writes with room (registered full) and 4-byte SR reads are legal.
    always_comb begin
        wr_ok = req && acc == BUS_ACC_4B && w_rb && addr == REG_SDR && !fifo_full;
        rd_ok = req && acc == BUS_ACC_4B && !w_rb && addr == REG_SR;
        fault = req && !(wr_ok || rd_ok);
    end

    audplay_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (wr_ok),
        .pop   (pop),
        .din   (wdata[SAMPLE_BITS-1:0]),
        .dout  (fifo_dout),
        .level (fifo_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Tick divider: one link tick every PRIMARY_DIV clocks, first tick right after reset.
    always_comb begin
        tick = div_q == '0;
        div_d = (div_q == DW'(PRIMARY_DIV - 1)) ? '0 : div_q + DW'(1);
    end

    // Link FSM: 64 ticks per state; leaving IDLE or HIGH into LOW loads a new sample.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load = 1'b0;
        if (tick) begin
            count_d = count_q + 6'd1;
            if (count_q == 6'(FRAME_HALF - 1)) begin
                state_d = (state_q == LINK_LOW) ? LINK_HIGH : LINK_LOW;
                load = state_q != LINK_LOW;
            end
        end
    end

    // Sample hold, sticky underrun (a same-cycle set beats the read clear) and read data.
    always_comb begin
        pop = load && !fifo_empty;
        hold_d = load ? (fifo_empty ? '0 : fifo_dout) : hold_q;
        underrun_d = (load && fifo_empty) || (underrun_q && !rd_ok);
        rdata_d = rd_ok ? sr_pack(fifo_empty, fifo_full, underrun_q, 4'(fifo_level)) : rdata_q;
    end

    // Registered state of the divider, link, sample path and bus response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q <= '0;
            state_q <= LINK_IDLE;
            count_q <= '0;
            hold_q <= '0;
            underrun_q <= 1'b0;
            resp_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            div_q <= div_d;
            state_q <= state_d;
            count_q <= count_d;
            hold_q <= hold_d;
            underrun_q <= underrun_d;
            resp_q <= wr_ok || rd_ok;
            rdata_q <= rdata_d;
        end
    end

    // Each bit occupies a count pair (2k, 2k+1), so sd moves only as sck falls.
    always_comb begin
        bit_idx = 5'd24 - count_q[5:1];
        sck = (state_q == LINK_IDLE) || count_q[0];
        ws = (state_q == LINK_IDLE) || (state_q == LINK_HIGH);
        sd = (state_q != LINK_IDLE && count_q >= 6'd2 && count_q <= 6'(2 * SAMPLE_BITS + 1))
             ? hold_q[bit_idx] : 1'b0;
    end

    assign resp  = resp_q;
    assign rdata = rdata_q;

endmodule
